// File: rtl/stopwatch_display_pkg.sv
// rtl/stopwatch_display_pkg.sv - segment glyphs and digit constants for the stopwatch display
package stopwatch_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam int NUM_DIGITS  = 4;
    localparam int COLON_DIGIT = 2;

    // Active-low, bit 6 = g ... bit 0 = a
    localparam seg7_t SEG_0     = 7'b1000000;
    localparam seg7_t SEG_1     = 7'b1111001;
    localparam seg7_t SEG_2     = 7'b0100100;
    localparam seg7_t SEG_3     = 7'b0110000;
    localparam seg7_t SEG_4     = 7'b0011001;
    localparam seg7_t SEG_5     = 7'b0010010;
    localparam seg7_t SEG_6     = 7'b0000010;
    localparam seg7_t SEG_7     = 7'b1111000;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0010000;
    localparam seg7_t SEG_DASH  = 7'b0111111;
    localparam seg7_t SEG_BLANK = 7'b1111111;

    function automatic logic [3:0] anode_sel(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/stopwatch_display_bcd_to_seg7.sv
// rtl/stopwatch_display_bcd_to_seg7.sv - BCD nibble to active-low seven-segment glyph, dash for 10-15
module bcd_to_seg7
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// rtl/stopwatch_display.sv - 4-digit multiplexed MM:SS display with blink modes; STOPWATCH_DISPLAY_LZB_EN blanks a zero minutes-tens digit
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic        clk_in,
    input  logic        RESET_N,
    input  logic [16:1] Q,
    input  logic        RUNNING,
    input  logic        AT_LIMIT,
    output logic [4:1]  AN,
    output logic [7:1]  SEG,
    output logic        DP
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   snap;
    logic [FW-1:0] frame_cnt;
    logic          phase;

    logic          tick;
    logic          wrap;
    logic [3:0]    nibble;
    seg7_t         dec_seg;
    logic [3:0]    an_nxt;
    seg7_t         seg_nxt;
    logic          dp_nxt;

    assign tick   = (presc == PW'(REFRESH_DIV - 1));
    assign wrap   = tick && (idx == 2'(NUM_DIGITS - 1));
    assign nibble = snap[{idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    // The tick cycle itself is rendered as an all-off guard so the anode switch never ghosts
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b1;
        if (!tick) begin
            an_nxt  = anode_sel(idx);
            seg_nxt = dec_seg;
            if (idx == 2'(COLON_DIGIT) && !AT_LIMIT)
                dp_nxt = RUNNING ? ~phase : 1'b0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
            if (idx == 2'd3 && nibble == 4'd0) begin
                an_nxt  = 4'b1111;
                seg_nxt = SEG_BLANK;
            end
`endif
            if (AT_LIMIT && !phase) begin
                an_nxt  = 4'b1111;
                seg_nxt = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            presc     <= '0;
            idx       <= 2'd0;
            snap      <= 16'd0;
            frame_cnt <= '0;
            phase     <= 1'b1;
            AN        <= 4'b1111;
            SEG       <= SEG_BLANK;
            DP        <= 1'b1;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            // Snapshot and blink bookkeeping share the frame boundary edge
            if (wrap) begin
                snap <= Q;
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            AN  <= an_nxt;
            SEG <= seg_nxt;
            DP  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// tb/tb_stopwatch_display.sv - table-driven scoreboard bench for stopwatch_display (REFRESH_DIV=4, BLINK_FRAMES=2)
module tb_stopwatch_display;

    localparam int RD = 4;
    localparam int BF = 2;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GB = 7'b1111111;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [16:1] q;
    logic        running;
    logic        at_limit;
    logic [4:1]  an;
    logic [7:1]  seg;
    logic        dp;

    always #5 clk_in = ~clk_in;

    stopwatch_display #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk_in   (clk_in),
        .RESET_N  (rst_n),
        .Q        (q),
        .RUNNING  (running),
        .AT_LIMIT (at_limit),
        .AN       (an),
        .SEG      (seg),
        .DP       (dp)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] q_mid;
        logic        run;
        logic        lim;
        logic [6:0]  g0;
        logic [6:0]  g1;
        logic [6:0]  g2;
        logic [6:0]  g3;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   passed = 0;
    int   total = 0;
    int   frame_no = 0;

    task automatic check(input string name, input exp_t e);
        total++;
        if (an === e.an && seg === e.seg && dp === e.dp)
            passed++;
        else
            $display("FAIL %s: got AN=%b SEG=%b DP=%b, required AN=%b SEG=%b DP=%b",
                     name, an, seg, dp, e.an, e.seg, e.dp);
    endtask

    task automatic cycle_check(input string name);
        exp_t e;
        @(posedge clk_in);
        @(negedge clk_in);
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty, got AN=%b", name, an);
        end else begin
            e = sb.pop_front();
            check(name, e);
        end
    endtask

    function automatic exp_t slot_exp(input int d, input logic [6:0] g, input logic [15:0] qv,
                                      input logic run, input logic lim, input logic ph,
                                      input logic guard);
        exp_t e;
        e.an  = 4'b1111;
        e.seg = GB;
        e.dp  = 1'b1;
        if (guard)
            return e;
        case (d)
            0:       e.an = 4'b1110;
            1:       e.an = 4'b1101;
            2:       e.an = 4'b1011;
            default: e.an = 4'b0111;
        endcase
        e.seg = g;
        if (d == 2 && !lim && (ph || !run))
            e.dp = 1'b0;
`ifdef STOPWATCH_DISPLAY_LZB_EN
        if (d == 3 && qv[15:12] == 4'd0) begin
            e.an  = 4'b1111;
            e.seg = GB;
        end
`endif
        if (lim && !ph) begin
            e.an  = 4'b1111;
            e.seg = GB;
        end
        return e;
    endfunction

    // One frame as seen on the pins: guard, digit x3, repeated for digits 0..3
    task automatic push_frame(input logic [15:0] qv, input logic run, input logic lim,
                              input logic ph, input logic [6:0] g0, input logic [6:0] g1,
                              input logic [6:0] g2, input logic [6:0] g3);
        logic [6:0] gl[4];
        gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
        for (int d = 0; d < 4; d++) begin
            sb.push_back(slot_exp(d, gl[d], qv, run, lim, ph, 1'b1));
            for (int r = 0; r < 3; r++)
                sb.push_back(slot_exp(d, gl[d], qv, run, lim, ph, 1'b0));
        end
    endtask

    task automatic play_vec(input vec_t v);
        logic ph;
        ph       = ((frame_no / 2) % 2) == 0;
        q        = v.q;
        running  = v.run;
        at_limit = v.lim;
        push_frame(v.q, v.run, v.lim, ph, v.g0, v.g1, v.g2, v.g3);
        for (int c = 0; c < 16; c++) begin
            if (c == 6)
                q = v.q_mid;
            cycle_check($sformatf("frame%0d_c%0d", frame_no, c));
        end
        frame_no++;
    endtask

    initial begin
        exp_t rst_e;
        rst_e.an  = 4'b1111;
        rst_e.seg = GB;
        rst_e.dp  = 1'b1;

        vecs[0]  = '{16'h2359, 16'h2359, 1'b0, 1'b0, G9, G5, G3, G2};
        vecs[1]  = '{16'h5947, 16'h5947, 1'b0, 1'b0, G7, G4, G9, G5};
        vecs[2]  = '{16'h000A, 16'h000A, 1'b1, 1'b0, GD, G0, G0, G0};
        vecs[3]  = '{16'h000A, 16'h000A, 1'b1, 1'b0, GD, G0, G0, G0};
        vecs[4]  = '{16'h0105, 16'h0105, 1'b1, 1'b0, G5, G0, G1, G0};
        vecs[5]  = '{16'h2359, 16'h2359, 1'b0, 1'b1, G9, G5, G3, G2};
        vecs[6]  = '{16'h2359, 16'h2359, 1'b1, 1'b1, G9, G5, G3, G2};
        vecs[7]  = '{16'h1068, 16'h1068, 1'b0, 1'b1, G8, G6, G0, G1};
        vecs[8]  = '{16'hBCDE, 16'hBCDE, 1'b0, 1'b0, GD, GD, GD, GD};
        vecs[9]  = '{16'h2359, 16'h2359, 1'b0, 1'b0, G9, G5, G3, G2};
        vecs[10] = '{16'h2359, 16'h1000, 1'b0, 1'b0, G9, G5, G3, G2};
        vecs[11] = '{16'h1000, 16'h1000, 1'b0, 1'b0, G0, G0, G0, G1};

        rst_n    = 1'b0;
        q        = 16'h7777;
        running  = 1'b0;
        at_limit = 1'b0;
        repeat (3) @(negedge clk_in);
        check("in_reset", rst_e);
        rst_n = 1'b1;
        #1;
        check("cycle0_guard", rst_e);

        // Frame 0 shows the reset snapshot (all zeros) regardless of Q
        push_frame(16'h0000, 1'b0, 1'b0, 1'b1, G0, G0, G0, G0);
        void'(sb.pop_front());
        for (int c = 0; c < 15; c++)
            cycle_check($sformatf("frame0_c%0d", c + 1));
        frame_no = 1;

        for (int i = 0; i < 12; i++)
            play_vec(vecs[i]);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", rst_e);
        repeat (2) @(negedge clk_in);
        check("reset_hold", rst_e);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
